// File: rtl/drm_sdp_fifo_if.sv
// User-side handshake of the DRM-backed FIFO: the producer/consumer (master) and the FIFO (slave).
interface drm_sdp_fifo_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
);
   logic              push;
   logic [DATA_W-1:0] push_data;
   logic              full;
   logic              almost_full;
   logic              pop;
   logic [DATA_W-1:0] pop_data;
   logic              pop_valid;
   logic              empty;
   logic              almost_empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output push, push_data, pop,
      input  full, almost_full, pop_data, pop_valid, empty, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  push, push_data, pop,
      output full, almost_full, pop_data, pop_valid, empty, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/drm_sdp_fifo_ctrl.sv
// FIFO controller sequencing an external simple-dual-port DRM with 1-cycle read latency.
// Pointers are ADDR_W bits; full/empty come from the occupancy count.
module drm_sdp_fifo_ctrl #(
   parameter int ADDR_W    = 7,
   parameter int DATA_W    = 8,
   parameter int AFULL_TH  = 120,
   parameter int AEMPTY_TH = 8
) (
   input  logic              clk,
   input  logic              rst,
   drm_sdp_fifo_if.slave     bus,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   output logic              ram_wr_byte_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data
);
   localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
   localparam logic [ADDR_W:0]   CNT_ONE  = 1;
   localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   AF_TH    = AFULL_TH[ADDR_W:0];
   localparam logic [ADDR_W:0]   AE_TH    = AEMPTY_TH[ADDR_W:0];

   logic [ADDR_W-1:0] wptr_reg, wptr_next;
   logic [ADDR_W-1:0] rptr_reg, rptr_next;
   logic [ADDR_W:0]   count_reg, count_next;
   logic              full_reg, empty_reg;
   logic              afull_reg, aempty_reg;
   logic              pop_valid_reg;
   logic              overflow_reg, underflow_reg;
   logic              push_acc, pop_acc;

   // Acceptance uses the registered flags, so a pop on an empty FIFO never bypasses a same-cycle push.
   always_comb begin
      push_acc   = bus.push & ~full_reg;
      pop_acc    = bus.pop & ~empty_reg;
      wptr_next  = wptr_reg;
      rptr_next  = rptr_reg;
      count_next = count_reg;
      if (push_acc) wptr_next = wptr_reg + PTR_ONE;
      if (pop_acc)  rptr_next = rptr_reg + PTR_ONE;
      case ({push_acc, pop_acc})
         2'b10:   count_next = count_reg + CNT_ONE;
         2'b01:   count_next = count_reg - CNT_ONE;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_reg      <= '0;
         rptr_reg      <= '0;
         count_reg     <= '0;
         full_reg      <= 1'b0;
         empty_reg     <= 1'b1;
         afull_reg     <= 1'b0;
         aempty_reg    <= 1'b1;
         pop_valid_reg <= 1'b0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         wptr_reg      <= wptr_next;
         rptr_reg      <= rptr_next;
         count_reg     <= count_next;
         full_reg      <= (count_next == CNT_FULL);
         empty_reg     <= (count_next == '0);
         afull_reg     <= (count_next >= AF_TH);
         aempty_reg    <= (count_next <= AE_TH);
         pop_valid_reg <= pop_acc;
         if (bus.push && full_reg)  overflow_reg  <= 1'b1;
         if (bus.pop  && empty_reg) underflow_reg <= 1'b1;
      end
   end

   assign ram_wr_en      = push_acc;
   assign ram_wr_addr    = wptr_reg;
   assign ram_wr_data    = bus.push_data;
   assign ram_wr_byte_en = 1'b1;
   assign ram_rd_addr    = rptr_reg;

   // The RAM has no output register, so its read data lines up with pop_valid directly.
   assign bus.pop_data     = ram_rd_data;
   assign bus.pop_valid    = pop_valid_reg;
   assign bus.full         = full_reg;
   assign bus.empty        = empty_reg;
   assign bus.almost_full  = afull_reg;
   assign bus.almost_empty = aempty_reg;
   assign bus.count        = count_reg;
   assign bus.overflow     = overflow_reg;
   assign bus.underflow    = underflow_reg;
endmodule
